// File: rtl/multiplier_pkg.sv
// Shared RISC-V M-extension definitions: op encodings, iteration count, FSM states
// and the operand magnitude helper.
package multiplier_pkg;

  typedef enum logic [1:0] {
    OpMul    = 2'b00,
    OpMulh   = 2'b01,
    OpMulhsu = 2'b10,
    OpMulhu  = 2'b11
  } m_op_e;

  localparam int unsigned MulIters = 32;
  localparam int unsigned CountW   = 5;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10
  } mul_state_e;

  // Absolute value in 33 bits so that -2^31 maps to +2^31 without overflow.
  function automatic logic [32:0] magnitude(input logic [31:0] v, input logic is_signed);
    logic [32:0] ext;
    ext = {v[31], v};
    if (is_signed && v[31]) begin
      return ~ext + 33'd1;
    end
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/multiplier_negate.sv
// Conditional two's-complement negator for the 64-bit product.
module mul_negate #(
  parameter int unsigned Width = 64
) (
  input  logic             neg_i,
  input  logic [Width-1:0] value_i,
  output logic [Width-1:0] value_o
);

  // Pass through or negate depending on the combined operand sign.
  always_comb begin
    value_o = value_i;
    if (neg_i) begin
      value_o = ~value_i + Width'(1);
    end
  end

endmodule

// File: rtl/multiplier.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU: 32 add steps on operand
// magnitudes, then one sign-fix cycle that selects the requested product half.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mul_state_e        state_q;
  m_op_e             op_q;
  logic [CountW-1:0] count_q;
  logic [63:0]       product_q;
  logic [32:0]       mcand_q;
  logic [32:0]       mplier_q;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       result_q;

  m_op_e       op_in;
  logic        sign_a;
  logic        sign_b;
  logic [32:0] mag_a;
  logic [32:0] mag_b;
  logic        neg_d;
  logic [63:0] addend;
  logic [63:0] product_d;
  logic [63:0] fixed_product;

  // Operand conditioning at acceptance and the per-step accumulate.
  always_comb begin
    op_in     = m_op_e'(op);
    sign_a    = (op_in == OpMulh) || (op_in == OpMulhsu);
    sign_b    = (op_in == OpMulh);
    mag_a     = magnitude(multiplicand, sign_a);
    mag_b     = magnitude(multiplier_in, sign_b);
    neg_d     = (sign_a & multiplicand[31]) ^ (sign_b & multiplier_in[31]);
    // Multiplicand stays fixed; shifting it by the step index aligns it with the
    // multiplier bit currently at mplier_q[0].
    addend    = {31'd0, mcand_q} << count_q;
    product_d = product_q;
    if (mplier_q[0]) begin
      product_d = product_q + addend;
    end
  end

  mul_negate #(
    .Width(64)
  ) u_negate (
    .neg_i  (neg_q),
    .value_i(product_q),
    .value_o(fixed_product)
  );

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      count_q   <= '0;
      product_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q      <= op_in;
            mcand_q   <= mag_a;
            mplier_q  <= mag_b;
            neg_q     <= neg_d;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          product_q <= product_d;
          mplier_q  <= mplier_q >> 1;
          count_q   <= count_q + CountW'(1);
          if (count_q == CountW'(MulIters - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_q <= (op_q == OpMul) ? fixed_product[31:0] : fixed_product[63:32];
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench: the driver pushes expected result and completion cycle, a
// monitor pops on every done pulse and also checks busy and result hold each cycle.
module tb_multiplier;

  localparam logic [1:0] MUL    = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] multiplicand;
  logic [31:0] multiplier_in;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          errors;
  int          checks;
  int          cyc;
  logic [31:0] last_res;

  multiplier #(
    .XLEN(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .multiplicand (multiplicand),
    .multiplier_in(multiplier_in),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full signed/unsigned product computed with plain wide arithmetic.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic signed [65:0] p;
    sa = (o == MULH || o == MULHSU) ? {{34{a[31]}}, a} : {34'd0, a};
    sb = (o == MULH) ? {{34{b[31]}}, b} : {34'd0, b};
    p  = sa * sb;
    return (o == MUL) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: done pulses against the scoreboard, busy and result hold every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        last_res = 32'd0;
      end else begin
        if (done) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: result 0x%08h at cycle %0d, expected no done",
                     result, cyc);
          end else begin
            e = sb_q.pop_front();
            check("result", result, e.res);
            check("latency", 32'(cyc), 32'(e.due));
            last_res = e.res;
          end
        end else begin
          check("result_hold", result, last_res);
        end
        check("busy", {31'd0, busy}, {31'd0, sb_q.size() != 0});
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    @(negedge clk);
    start         = 1'b1;
    op            = o;
    multiplicand  = a;
    multiplier_in = b;
    @(posedge clk);
    #1;
    sb_q.push_back('{res: exp, due: cyc + 33});
    start         = 1'b0;
    op            = 2'($urandom);
    multiplicand  = $urandom;
    multiplier_in = $urandom;
  endtask

  // Lands on the edge that completes the operation, so a following issue starts
  // in the done cycle.
  task automatic finish_op();
    repeat (33) @(posedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  o;
    errors        = 0;
    checks        = 0;
    last_res      = 32'd0;
    rst           = 1'b1;
    start         = 1'b0;
    op            = MUL;
    multiplicand  = 32'd0;
    multiplier_in = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    #2 rst = 1'b0;

    // Directed vectors, issued back to back.
    issue(MUL, 32'd7, 32'd6, 32'h0000_002A);
    finish_op();
    issue(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    finish_op();
    issue(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    finish_op();
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    finish_op();
    issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op();
    issue(MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    finish_op();
    issue(MUL, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
    finish_op();
    issue(MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    finish_op();
    issue(MUL, 32'd0, 32'h1234_5678, 32'h0000_0000);
    finish_op();

    // A start while busy must be ignored.
    issue(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start         = 1'b1;
    op            = MUL;
    multiplicand  = 32'd3;
    multiplier_in = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (28) @(posedge clk);

    // Reset in the middle of CALC aborts without a done.
    issue(MULH, 32'hDEAD_BEEF, 32'h1357_9BDF, ref_mul(MULH, 32'hDEAD_BEEF, 32'h1357_9BDF));
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    issue(MUL, 32'd3, 32'd5, 32'h0000_000F);
    finish_op();

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      a = pick_operand();
      b = pick_operand();
      o = 2'($urandom);
      issue(o, a, b, ref_mul(o, a, b));
      finish_op();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
